// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Package  : keypad_pkg -- key FSM states, key map, debounce default
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAND = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } key_state_t;

    localparam int DEBOUNCE_DEFAULT = 3;

    // Indexed by {row, col}; row 3 carries the E/0/F/D bottom line.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage
`default_nettype wire

// File: rtl/keypad_key_map.sv
`default_nettype none
// ============================================================================
// Module   : keypad_key_map -- combinational {row, col} -> nibble decode
// Revision : 1.0 - initial release
// ============================================================================
module keypad_key_map
    import keypad_pkg::*;
(
    input  logic [1:0] i_row_idx,
    input  logic [1:0] i_col_idx,
    output logic [3:0] o_nibble
);

    assign o_nibble = KEY_MAP[{i_row_idx, i_col_idx}];

endmodule
`default_nettype wire

// File: rtl/hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : hex_keypad_entry -- 4x4 scanned keypad, 3-digit hex entry with enter
// Config   : KEYPAD_BACKSPACE_EN makes key F delete the newest digit
// Revision : 1.0 - initial release
// ============================================================================
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W = 16,
    parameter int DEBOUNCE   = DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        btn_enter,
    output logic [11:0] entry,
    output logic [11:0] data_out,
    output logic        data_valid,
    input  logic        data_ack,
    output logic        new_data
);

    localparam logic [3:0] c_DEB = 4'(DEBOUNCE);

    logic [SCAN_DIV_W-1:0] r_presc;
    logic [1:0]            r_col_idx;
    logic [1:0]            r_acc_hits;
    logic [3:0]            r_acc_key;
    key_state_t            r_state;
    logic [3:0]            r_count;
    logic [3:0]            r_cand;
    logic                  r_enter_db;
    logic [3:0]            r_enter_cnt;
    logic [11:0]           r_entry;
    logic [11:0]           r_data_out;
    logic                  r_data_valid;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [3:0]            w_row_low;
    logic                  w_row_one;
    logic [1:0]            w_row_idx;
    logic [3:0]            w_map_nib;
    logic [1:0]            w_hits;
    logic [3:0]            w_frame_key;
    logic                  w_frame_one;
    logic                  w_frame_idle;
    key_state_t            w_state_nxt;
    logic [3:0]            w_count_nxt;
    logic [3:0]            w_cand_nxt;
    logic [3:0]            w_count_inc;
    logic                  w_accept;
    logic                  w_enter_evt;
    logic                  w_capture;
    logic [11:0]           w_entry_base;
    logic [11:0]           w_entry_nxt;

    assign w_tick      = &r_presc;
    assign w_frame_end = w_tick && (r_col_idx == 2'd3);
    assign col         = ~(4'b0001 << r_col_idx);

    // Row sample of the column currently driven
    assign w_row_low = ~row;
    assign w_row_one = (w_row_low != 4'd0) && ((w_row_low & (w_row_low - 4'd1)) == 4'd0);

    always_comb begin
        w_row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_row_low[i]) w_row_idx = 2'(i);
        end
    end

    keypad_key_map u_key_map (
        .i_row_idx (w_row_idx),
        .i_col_idx (r_col_idx),
        .o_nibble  (w_map_nib)
    );

    // Hit count saturates at 2, which is all "invalid" needs
    always_comb begin
        w_hits = r_acc_hits;
        if (w_row_low != 4'd0) begin
            w_hits = (w_row_one && (r_acc_hits == 2'd0)) ? 2'd1 : 2'd2;
        end
    end

    assign w_frame_key  = (r_acc_hits != 2'd0) ? r_acc_key : w_map_nib;
    assign w_frame_one  = (w_hits == 2'd1);
    assign w_frame_idle = (w_hits == 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_col_idx  <= 2'd0;
            r_acc_hits <= 2'd0;
            r_acc_key  <= 4'd0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_tick) begin
                r_col_idx <= r_col_idx + 2'd1;
                if (r_col_idx == 2'd3) begin
                    r_acc_hits <= 2'd0;
                    r_acc_key  <= 4'd0;
                end else begin
                    r_acc_hits <= w_hits;
                    r_acc_key  <= w_frame_key;
                end
            end
        end
    end

    assign w_count_inc = r_count + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_one) begin
                        w_cand_nxt = w_frame_key;
                        if (c_DEB == 4'd1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_HELD;
                            w_count_nxt = 4'd0;
                        end else begin
                            w_state_nxt = ST_CAND;
                            w_count_nxt = 4'd1;
                        end
                    end
                end
                ST_CAND: begin
                    if (w_frame_one && (w_frame_key == r_cand)) begin
                        if (w_count_inc == c_DEB) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_HELD;
                            w_count_nxt = 4'd0;
                        end else begin
                            w_count_nxt = w_count_inc;
                        end
                    end else if (w_frame_one) begin
                        w_cand_nxt  = w_frame_key;
                        w_count_nxt = 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (w_frame_idle) begin
                        w_state_nxt = (c_DEB == 4'd1) ? ST_IDLE : ST_REL;
                        w_count_nxt = (c_DEB == 4'd1) ? 4'd0 : 4'd1;
                    end
                end
                ST_REL: begin
                    if (!w_frame_idle) begin
                        w_state_nxt = ST_HELD;
                        w_count_nxt = 4'd0;
                    end else if (w_count_inc == c_DEB) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = 4'd0;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    assign w_enter_evt = w_frame_end && btn_enter && !r_enter_db
                         && ((r_enter_cnt + 4'd1) == c_DEB);
    assign w_capture   = w_enter_evt && (!r_data_valid || data_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_enter_db  <= 1'b0;
            r_enter_cnt <= 4'd0;
        end else if (w_frame_end) begin
            if (btn_enter != r_enter_db) begin
                if ((r_enter_cnt + 4'd1) == c_DEB) begin
                    r_enter_db  <= btn_enter;
                    r_enter_cnt <= 4'd0;
                end else begin
                    r_enter_cnt <= r_enter_cnt + 4'd1;
                end
            end else begin
                r_enter_cnt <= 4'd0;
            end
        end
    end

    // A capture empties the entry first, so a same-frame key lands on a clean slate
    assign w_entry_base = w_capture ? 12'h000 : r_entry;

    always_comb begin
        w_entry_nxt = w_entry_base;
        if (w_accept) begin
`ifdef KEYPAD_BACKSPACE_EN
            if (w_frame_key == 4'hF) begin
                w_entry_nxt = {4'h0, w_entry_base[11:4]};
            end else begin
                w_entry_nxt = {w_entry_base[7:0], w_frame_key};
            end
`else
            w_entry_nxt = {w_entry_base[7:0], w_frame_key};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_entry      <= 12'h000;
            r_data_out   <= 12'h000;
            r_data_valid <= 1'b0;
        end else begin
            r_entry <= w_entry_nxt;
            if (w_capture) begin
                r_data_out   <= r_entry;
                r_data_valid <= 1'b1;
            end else if (data_ack) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign entry      = r_entry;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign new_data   = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_keypad_entry -- scoreboard bench for hex_keypad_entry
// Config   : follows KEYPAD_BACKSPACE_EN for the expected F-key behaviour
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_entry;

    localparam int c_DIV_W = 4;
    localparam int c_DEB   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        btn_enter = 1'b0;
    logic        data_ack = 1'b0;
    logic [11:0] entry;
    logic [11:0] data_out;
    logic        data_valid;
    logic        new_data;

    logic [15:0] r_pressed = 16'h0000;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] q_entry [$];
    logic [11:0] q_data  [$];
    logic [11:0] m_entry = 12'h000;
    logic [11:0] m_dout  = 12'h000;

    logic [11:0] r_prev_entry;
    logic [11:0] r_prev_dout;
    logic [3:0]  r_prev_col;
    int          r_col_cycles;
    logic        r_col_seen;

    always #5 clk = ~clk;

    hex_keypad_entry #(
        .SCAN_DIV_W (c_DIV_W),
        .DEBOUNCE   (c_DEB)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .btn_enter  (btn_enter),
        .entry      (entry),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .new_data   (new_data)
    );

    // Keypad matrix: a pressed key shorts its row to its column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int key_pos(input logic [3:0] nib);
        case (nib)
            4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
            4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
            4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
            4'hE: return 12;  4'h0: return 13;  4'hF: return 14;  default: return 15;
        endcase
    endfunction

    function automatic logic [11:0] model_key(input logic [11:0] e, input logic [3:0] nib);
`ifdef KEYPAD_BACKSPACE_EN
        if (nib == 4'hF) return {4'h0, e[11:4]};
`endif
        return {e[7:0], nib};
    endfunction

    // Scoreboard monitor: every change of entry/data_out must match the next expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            r_prev_entry <= entry;
            r_prev_dout  <= data_out;
            r_prev_col   <= col;
            r_col_cycles <= 0;
            r_col_seen   <= 1'b0;
        end else begin
            if (entry !== r_prev_entry) begin
                if (q_entry.size() == 0) check_eq("entry_spurious", 32'(entry), 32'(r_prev_entry));
                else check_eq("entry", 32'(entry), 32'(q_entry.pop_front()));
            end
            if (data_out !== r_prev_dout) begin
                if (q_data.size() == 0) check_eq("dout_spurious", 32'(data_out), 32'(r_prev_dout));
                else check_eq("data_out", 32'(data_out), 32'(q_data.pop_front()));
            end
            if (col !== r_prev_col) begin
                check_eq("col_seq", 32'(col), 32'({r_prev_col[2:0], r_prev_col[3]}));
                if (r_col_seen) check_eq("col_period", 32'(r_col_cycles + 1), 32'd16);
                r_col_seen   <= 1'b1;
                r_col_cycles <= 0;
            end else begin
                r_col_cycles <= r_col_cycles + 1;
            end
            r_prev_entry <= entry;
            r_prev_dout  <= data_out;
            r_prev_col   <= col;
        end
    end

    task automatic next_frame();
        logic [3:0] prev;
        bit         done;
        prev = col;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && col == 4'b1110) done = 1'b1;
            prev = col;
        end
        if (!done) check_eq("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic frames(input int n);
        repeat (n) next_frame();
    endtask

    task automatic tap(input logic [3:0] nib, input int hold);
        logic [11:0] nxt;
        r_pressed = 16'h0001 << key_pos(nib);
        if (hold >= c_DEB) begin
            nxt = model_key(m_entry, nib);
            if (nxt != m_entry) q_entry.push_back(nxt);
            m_entry = nxt;
        end
        frames(hold);
        r_pressed = 16'h0000;
        frames(4);
    endtask

    task automatic expect_capture(input logic [11:0] after_entry);
        if (m_entry != m_dout) q_data.push_back(m_entry);
        m_dout = m_entry;
        if (after_entry != m_entry) q_entry.push_back(after_entry);
        m_entry = after_entry;
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check_eq("rst_col", 32'(col), 32'b1110);
        check_eq("rst_entry", 32'(entry), 32'h0);
        check_eq("rst_dout", 32'(data_out), 32'h0);
        check_eq("rst_valid", 32'(data_valid), 32'h0);
        check_eq("rst_new", 32'(new_data), 32'h0);
        rst_n = 1'b1;

        repeat (1000) @(negedge clk);
        check_eq("idle_entry", 32'(entry), 32'h0);
        check_eq("idle_valid", 32'(data_valid), 32'h0);

        next_frame();
        tap(4'h5, 4);
        tap(4'h2, 4);
        tap(4'hA, 4);
        check_eq("entry_52A", 32'(entry), 32'h52A);

        // Bouncing key never reaches the debounce count
        for (int i = 0; i < 3; i++) begin
            r_pressed = 16'h0001 << key_pos(4'h7);
            frames(1);
            r_pressed = 16'h0000;
            frames(1);
        end
        r_pressed = 16'h0001 << key_pos(4'h7);
        frames(2);
        r_pressed = 16'h0000;
        frames(4);
        check_eq("bounce_entry", 32'(entry), 32'h52A);

        tap(4'hF, 4);
`ifdef KEYPAD_BACKSPACE_EN
        check_eq("key_F", 32'(entry), 32'h052);
`else
        check_eq("key_F", 32'(entry), 32'h2AF);
`endif
        tap(4'h1, 4);
        tap(4'hF, 4);
        tap(4'h3, 4);
        check_eq("entry_pre_enter", 32'(entry), 32'(m_entry));

        // First enter captures the entry
        expect_capture(12'h000);
        btn_enter = 1'b1;
        frames(4);
        btn_enter = 1'b0;
        check_eq("enter_dout", 32'(data_out), 32'(m_dout));
        check_eq("enter_valid", 32'(data_valid), 32'h1);
        check_eq("enter_entry", 32'(entry), 32'h0);
        frames(4);

        // Second enter before ack is dropped
        tap(4'h7, 4);
        btn_enter = 1'b1;
        frames(4);
        btn_enter = 1'b0;
        frames(4);
        check_eq("drop_dout", 32'(data_out), 32'(m_dout));
        check_eq("drop_entry", 32'(entry), 32'h007);
        check_eq("drop_valid", 32'(data_valid), 32'h1);

        @(negedge clk) data_ack = 1'b1;
        @(negedge clk) data_ack = 1'b0;
        check_eq("ack_valid", 32'(data_valid), 32'h0);
        check_eq("ack_new", 32'(new_data), 32'h0);
        @(negedge clk) data_ack = 1'b1;
        @(negedge clk) data_ack = 1'b0;
        check_eq("ack_idle_valid", 32'(data_valid), 32'h0);

        // Multiple keys: invalid frames
        r_pressed = (16'h0001 << key_pos(4'h3)) | (16'h0001 << key_pos(4'h6));
        frames(4);
        r_pressed = (16'h0001 << key_pos(4'h1)) | (16'h0001 << key_pos(4'hD));
        frames(4);
        r_pressed = 16'h0000;
        frames(4);
        check_eq("invalid_entry", 32'(entry), 32'h007);

        // Key accept and enter in the same frame
        expect_capture(model_key(12'h000, 4'h8));
        r_pressed = 16'h0001 << key_pos(4'h8);
        btn_enter = 1'b1;
        frames(4);
        r_pressed = 16'h0000;
        btn_enter = 1'b0;
        frames(4);
        check_eq("same_dout", 32'(data_out), 32'h007);
        check_eq("same_entry", 32'(entry), 32'h008);
        check_eq("same_valid", 32'(data_valid), 32'h1);

        // Enter with ack in the same cycle reloads data_out and keeps valid
        expect_capture(12'h000);
        btn_enter = 1'b1;
        frames(2);
        for (int i = 0; i < 100 && col != 4'b0111; i++) @(negedge clk);
        repeat (15) @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check_eq("ackenter_col", 32'(col), 32'b1110);
        check_eq("ackenter_dout", 32'(data_out), 32'h008);
        check_eq("ackenter_valid", 32'(data_valid), 32'h1);
        btn_enter = 1'b0;
        frames(4);

        // Reset in the middle of a press discards partial debounce
        r_pressed = 16'h0001 << key_pos(4'h9);
        frames(2);
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_entry = 12'h000;
        m_dout  = 12'h000;
        check_eq("midrst_valid", 32'(data_valid), 32'h0);
        frames(2);
        check_eq("midrst_entry", 32'(entry), 32'h0);
        q_entry.push_back(12'h009);
        m_entry = 12'h009;
        frames(1);
        r_pressed = 16'h0000;
        frames(4);
        check_eq("midrst_accept", 32'(entry), 32'h009);

        check_eq("q_entry_empty", 32'(q_entry.size()), 32'd0);
        check_eq("q_data_empty", 32'(q_data.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/hex_keypad_entry.md
HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 Parameter SCAN_DIV_W, default 16: prescaler width; one column tick every 2^SCAN_DIV_W clocks.
REQ-002 Parameter DEBOUNCE, default 3: consecutive identical frames required to accept a press, release or enter change (range 1..15).
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 row  input  4  keypad rows, active-low, externally pulled up.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low.
REQ-007 btn_enter  input  1  raw enter button, active-high, undebounced.
REQ-008 entry  output  12  digits typed so far, newest in [3:0], for display echo.
REQ-009 data_out  output  12  value captured at the last accepted enter.
REQ-010 data_valid  output  1  data_out holds an unconsumed value.
REQ-011 data_ack  input  1  consumer accepts data_out.
REQ-012 new_data  output  1  equals data_valid; drives the display decimal point.

Function
REQ-013 The prescaler increments every clock; tick = prescaler all-ones; on a tick it wraps to 0.
REQ-014 On a tick, the block samples row for the column currently driven, then advances to the next column (0,1,2,3,0...); col = ~(1 << index).
REQ-015 A frame is four ticks, columns 0..3; the frame result is taken on the column-3 tick: one key low = that key, none = idle, two or more = invalid.
REQ-016 Key map (row,col -> nibble): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
REQ-017 The key FSM has states IDLE, CAND, HELD and REL; it is evaluated only at frame end.
REQ-018 IDLE: a single key loads the candidate, count=1 and goes to CAND; idle or invalid stays IDLE.
REQ-019 CAND: the same key increments count; at count==DEBOUNCE it accepts and goes to HELD; a different key restarts the candidate; idle or invalid returns to IDLE.
REQ-020 Accept shifts entry <= {entry[7:0], nibble}; the oldest nibble is discarded, with no saturation.
REQ-021 HELD: idle goes to REL with count=1; any key pressed, or an invalid frame, stays HELD and produces no repeat.
REQ-022 REL: idle increments count; at count==DEBOUNCE it goes to IDLE; any key pressed returns to HELD.
REQ-023 btn_enter is sampled at frame end; the debounced level changes only after DEBOUNCE consecutive differing samples; an enter event is a debounced 0->1.
REQ-024 On an enter event with data_valid=0: data_out <= entry, data_valid <= 1, entry <= 0.
REQ-025 On an enter event with data_valid=1 and data_ack=0: the event is dropped and entry is unchanged.
REQ-026 data_ack with data_valid=1 clears data_valid on the next edge; data_ack with data_valid=0 is ignored.
REQ-027 Enter event with data_valid=1 and data_ack=1 in the same cycle: data_out loads entry and data_valid stays 1.
REQ-028 Key accept and enter event in the same frame: enter captures the pre-shift entry, and entry becomes {8'h000, nibble}.
REQ-029 Latency: entry updates one clock after the frame-end tick of the accepting frame.

Reset
REQ-030 While rst_n=0 at a clock edge: prescaler=0, column index=0 (col=4'b1110), FSM=IDLE, counts=0, debounced enter=0, entry=0, data_out=0, data_valid=0.
REQ-031 Reset mid-press discards any partial debounce; a key still held after reset must debounce afresh from IDLE.

Configuration
REQ-032 With macro KEYPAD_BACKSPACE_EN defined, key F acts as backspace: accept sets entry <= {4'h0, entry[11:4]}.
REQ-033 Without KEYPAD_BACKSPACE_EN, key F is the digit 4'hF, like any other key.

Structure
REQ-034 Package keypad_pkg shall hold the FSM state enum, the 16-entry key map constant and the DEBOUNCE default.
REQ-035 One sub-module, keypad_key_map, shall be combinational: {row index, col index} -> nibble.

Verification (SCAN_DIV_W=4, DEBOUNCE=3; tick every 16 clocks, frame 64 clocks)
REQ-036 Reset, then idle for 1000 clocks -> col cycles 1110,1101,1011,0111; entry=0; data_valid=0.
REQ-037 Hold key 5 (row1, col1) for 4 frames, release, then key 2 and key A the same way -> entry=12'h52A, one shift per press.
REQ-038 Key 7 bouncing (alternating press/idle frames) for 6 frames, then held for 2 frames -> no accept; entry unchanged.
REQ-039 entry=12'h1F3, btn_enter high for 4 frames -> data_out=12'h1F3, data_valid=1, entry=0; a second enter before data_ack leaves data_out unchanged.
REQ-040 Pulse data_ack for 1 clock -> data_valid=0 next clock; keys 3 and 6 held together -> invalid frames, no accept.
REQ-041 With KEYPAD_BACKSPACE_EN, entry=12'h52A and F pressed -> entry=12'h052; without the macro -> entry=12'h2AF.
